// File: rtl/i2c_controller.sv
// Single-byte register-access I2C initiator: write, or read via repeated START.
// Open-drain SCL/SDA (1 = release), synchronized bus sampling, honours clock stretching.
module i2c_controller #(
    parameter int QUARTER = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SCL_out,
    output logic       SDA_out
);
    localparam int TW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(QUARTER - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_WDATA, S_ACK3,
        S_RSTART, S_ADDR_R, S_ACK4, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tmr;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic          r_rw;
    logic [6:0]    r_dev;
    logic [7:0]    r_reg, r_wdata, r_rx, r_rdata;
    logic          r_nack, r_smp;
    logic [1:0]    r_scl_sync, r_sda_sync;

    logic       w_scl_s, w_sda_s, w_active, w_wait_q, w_hold, w_qend, w_bit_end;
    logic       w_is_byte, w_is_ack, w_step, w_set_nack, w_scl, w_sda;
    logic [7:0] w_tx_byte;

    assign w_scl_s   = r_scl_sync[1];
    assign w_sda_s   = r_sda_sync[1];
    assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_is_ack  = (r_state == S_ACK1) || (r_state == S_ACK2) ||
                       (r_state == S_ACK3) || (r_state == S_ACK4);
    // Stretch wait: the timer only starts counting the SCL-high quarter once the bus really is high.
    assign w_hold    = w_wait_q && (r_tmr == '0) && !w_scl_s;
    assign w_qend    = w_active && !w_hold && (r_tmr == TMR_LAST);
    assign w_bit_end = w_qend && (r_q == 2'd3);
    assign w_step    = w_bit_end && (!w_is_byte || (r_bit == 3'd7));

    // Byte driven MSB first; ACK/MNACK/RDATA slots drive all-ones so SDA stays released.
    always_comb begin
        w_tx_byte = 8'hFF;
        w_is_byte = 1'b0;
        case (r_state)
            S_ADDR_W: begin w_tx_byte = {r_dev, 1'b0}; w_is_byte = 1'b1; end
            S_REG:    begin w_tx_byte = r_reg;         w_is_byte = 1'b1; end
            S_WDATA:  begin w_tx_byte = r_wdata;       w_is_byte = 1'b1; end
            S_ADDR_R: begin w_tx_byte = {r_dev, 1'b1}; w_is_byte = 1'b1; end
            S_RDATA:  w_is_byte = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        w_scl    = 1'b1;
        w_sda    = 1'b1;
        w_wait_q = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: ;
            S_START: begin
                w_scl = !r_q[1];
                w_sda = (r_q == 2'd0);
            end
            S_RSTART: begin
                w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda    = !r_q[1];
                w_wait_q = (r_q == 2'd1);
            end
            S_STOP: begin
                w_scl    = (r_q != 2'd0);
                w_sda    = r_q[1];
                w_wait_q = (r_q == 2'd1);
            end
            default: begin
                w_scl    = r_q[1];
                w_sda    = w_tx_byte[3'd7 - r_bit];
                w_wait_q = (r_q == 2'd2);
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_set_nack   = 1'b0;
        case (r_state)
            S_IDLE: if (start_req) w_state_next = S_START;
            S_DONE: w_state_next = S_IDLE;
            default: if (w_step) begin
                case (r_state)
                    S_START:  w_state_next = S_ADDR_W;
                    S_ADDR_W: w_state_next = S_ACK1;
                    S_ACK1:   w_state_next = S_REG;
                    S_REG:    w_state_next = S_ACK2;
                    S_ACK2:   w_state_next = r_rw ? S_RSTART : S_WDATA;
                    S_WDATA:  w_state_next = S_ACK3;
                    S_ACK3:   w_state_next = S_STOP;
                    S_RSTART: w_state_next = S_ADDR_R;
                    S_ADDR_R: w_state_next = S_ACK4;
                    S_ACK4:   w_state_next = S_RDATA;
                    S_RDATA:  w_state_next = S_MNACK;
                    S_MNACK:  w_state_next = S_STOP;
                    S_STOP:   w_state_next = S_DONE;
                    default:  w_state_next = S_IDLE;
                endcase
                if (w_is_ack && r_smp) begin
                    w_state_next = S_STOP;
                    w_set_nack   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_q        <= '0;
            r_bit      <= '0;
            r_rw       <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_wdata    <= '0;
            r_rx       <= '0;
            r_rdata    <= '0;
            r_nack     <= 1'b0;
            r_smp      <= 1'b0;
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_state    <= w_state_next;
            r_scl_sync <= {r_scl_sync[0], SCL_in};
            r_sda_sync <= {r_sda_sync[0], SDA_in};
            if ((r_state == S_IDLE) && start_req) begin
                r_rw    <= rw;
                r_dev   <= dev_addr;
                r_reg   <= reg_addr;
                r_wdata <= wdata;
                r_nack  <= 1'b0;
            end
            if (w_set_nack) r_nack <= 1'b1;
            if (!w_active) begin
                r_tmr <= '0;
                r_q   <= '0;
                r_bit <= '0;
            end else if (w_qend) begin
                r_tmr <= '0;
                r_q   <= r_q + 2'd1;
                if (r_q == 2'd2) begin
                    r_smp <= w_sda_s;
                    if (r_state == S_RDATA) begin
                        r_rx <= {r_rx[6:0], w_sda_s};
                        if (r_bit == 3'd7) r_rdata <= {r_rx[6:0], w_sda_s};
                    end
                end
                if (r_q == 2'd3) r_bit <= (w_state_next != r_state) ? 3'd0 : r_bit + 3'd1;
            end else if (!w_hold) begin
                r_tmr <= r_tmr + TW'(1);
            end
        end
    end

    assign SCL_out = w_scl;
    assign SDA_out = w_sda;
    assign busy    = w_active;
    assign done    = (r_state == S_DONE);
    assign nack    = r_nack;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: wired-AND bus with a behavioural register target,
// bus-level event decoder, and an expected-event model per transaction.
module tb_i2c_controller;
    localparam int Q = 8;
    localparam int EV_S = 'h1000;
    localparam int EV_P = 'h2000;
    localparam logic [6:0] TGT_ADDR = 7'h49;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev = '0;
    logic [7:0] regad = '0;
    logic [7:0] wd = '0;
    logic [7:0] rdata;
    logic       busy, done, nack;
    logic       SCL_out, SDA_out;
    logic       tgt_scl = 1'b1;
    logic       tgt_sda = 1'b1;
    logic       scl_bus, sda_bus;

    assign scl_bus = SCL_out & tgt_scl;
    assign sda_bus = SDA_out & tgt_sda;

    always #5 clk = ~clk;

    i2c_controller #(.QUARTER(Q)) dut (
        .clock(clk), .reset(rst), .start_req(start_req), .rw(rw),
        .dev_addr(dev), .reg_addr(regad), .wdata(wd),
        .rdata(rdata), .busy(busy), .done(done), .nack(nack),
        .SCL_in(scl_bus), .SDA_in(sda_bus), .SCL_out(SCL_out), .SDA_out(SDA_out)
    );

    int total = 0;
    int bad = 0;

    // Bus observation and target state
    int         events[$];
    int         exp_ev[$];
    bit         exp_nack = 1'b0;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] tgt_rd = 8'h00;
    bit         present = 1'b1;
    bit         stretch_arm = 1'b0;
    int         stretch_cnt = 0;
    int         done_cnt = 0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    logic [8:0] sh = '0;
    int         bitcnt = 0;
    int         byteidx = 0;
    bit         hit = 1'b0;
    bit         is_rd = 1'b0;
    bit         tx_mode = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) tgt_scl = 1'b1;
            end
            if (scl_p && scl_bus && sda_p && !sda_bus) begin
                events.push_back(EV_S);
                bitcnt = 0; byteidx = 0; hit = 1'b0; tx_mode = 1'b0; tgt_sda = 1'b1;
            end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
                events.push_back(EV_P);
                bitcnt = 0; byteidx = 0; hit = 1'b0; tx_mode = 1'b0; tgt_sda = 1'b1;
            end else if (!scl_p && scl_bus) begin
                sh = {sh[7:0], sda_bus};
                bitcnt++;
                if (bitcnt == 8 && byteidx == 0) begin
                    hit   = present && (sh[7:1] == TGT_ADDR);
                    is_rd = sh[0];
                end
                if (bitcnt == 9) begin
                    events.push_back(int'(sh));
                    tx_mode = (byteidx == 0) && hit && is_rd;
                    bitcnt  = 0;
                    byteidx++;
                end
            end else if (scl_p && !scl_bus) begin
                if (bitcnt == 8)   tgt_sda = (tx_mode || !hit) ? 1'b1 : 1'b0;
                else if (tx_mode)  tgt_sda = tgt_rd[7 - bitcnt];
                else               tgt_sda = 1'b1;
                if (stretch_arm && byteidx == 1 && bitcnt == 4) begin
                    stretch_arm = 1'b0;
                    tgt_scl     = 1'b0;
                    stretch_cnt = 2 * Q + 50;
                end
            end
            scl_p = scl_bus;
            sda_p = sda_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected bus events: START, bytes as {byte, ack bit}, STOP.
    task automatic model_txn(input bit r, input logic [6:0] d, input logic [7:0] ra,
                             input logic [7:0] w, input logic [7:0] rd);
        bit h;
        h = present && (d == TGT_ADDR);
        exp_ev.delete();
        exp_ev.push_back(EV_S);
        exp_ev.push_back(int'({d, 1'b0, ~h}));
        if (!h) begin
            exp_nack = 1'b1;
        end else begin
            exp_nack = 1'b0;
            exp_ev.push_back(int'({ra, 1'b0}));
            if (!r) begin
                exp_ev.push_back(int'({w, 1'b0}));
            end else begin
                exp_ev.push_back(EV_S);
                exp_ev.push_back(int'({d, 1'b1, 1'b0}));
                exp_ev.push_back(int'({rd, 1'b1}));
                exp_rdata = rd;
            end
        end
        exp_ev.push_back(EV_P);
    endtask

    task automatic start_txn(input bit r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] w);
        events.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start_req = 1'b1; rw = r; dev = d; regad = ra; wd = w;
        @(posedge clk); #1;
        start_req = 1'b0;
    endtask

    task automatic finish_txn(output int dur);
        dur = 0;
        while (done !== 1'b1 && dur < 6000) begin
            @(negedge clk);
            dur++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_txn(input string tag);
        chk({tag, "_nevents"}, events.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < events.size(); i++)
            chk({tag, "_event"}, events[i], exp_ev[i]);
        chk({tag, "_nack"}, nack, exp_nack);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        $display("txn %s: events=%0d nack=%0d rdata=%02h", tag, events.size(), nack, rdata);
    endtask

    int dur_w, dur_s, dur_x, n;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl", SCL_out, 1);
        chk("rst_sda", SDA_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_rdata", rdata, 8'h00);
        @(posedge clk); #1 rst = 1'b0;

        tgt_rd = 8'h00;
        model_txn(1'b0, 7'h49, 8'h03, 8'hA5, 8'h00);
        start_txn(1'b0, 7'h49, 8'h03, 8'hA5);
        finish_txn(dur_w);
        check_txn("write");

        tgt_rd = 8'h3C;
        model_txn(1'b1, 7'h49, 8'h07, 8'h00, 8'h3C);
        start_txn(1'b1, 7'h49, 8'h07, 8'h00);
        finish_txn(dur_x);
        check_txn("read");

        present = 1'b0;
        model_txn(1'b0, 7'h49, 8'h11, 8'h22, 8'h00);
        start_txn(1'b0, 7'h49, 8'h11, 8'h22);
        finish_txn(dur_x);
        check_txn("no_target");
        present = 1'b1;

        stretch_arm = 1'b1;
        model_txn(1'b0, 7'h49, 8'h03, 8'hA5, 8'h00);
        start_txn(1'b0, 7'h49, 8'h03, 8'hA5);
        finish_txn(dur_s);
        check_txn("stretch");
        $display("stretch extension: %0d clocks", dur_s - dur_w);
        chk("stretch_extension_in_range", (dur_s - dur_w >= 46) && (dur_s - dur_w <= 54), 1);

        start_txn(1'b0, 7'h49, 8'h05, 8'h5A);
        n = 0;
        while (!(byteidx == 2 && bitcnt == 3 && scl_bus == 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wdata_bit3", n < 3000, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", SCL_out, 1);
        chk("midrst_sda", SDA_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_rdata", rdata, 8'h00);
        exp_rdata = 8'h00;
        $display("txn mid_reset: aborted, done_pulses=%0d", done_cnt);

        model_txn(1'b0, 7'h49, 8'h06, 8'hC3, 8'h00);
        start_txn(1'b0, 7'h49, 8'h06, 8'hC3);
        finish_txn(dur_x);
        check_txn("after_reset");

        model_txn(1'b0, 7'h49, 8'h0A, 8'h77, 8'h00);
        start_txn(1'b0, 7'h49, 8'h0A, 8'h77);
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        start_req = 1'b1; rw = 1'b1; dev = 7'h22; regad = 8'hFF; wd = 8'h00;
        @(posedge clk); #1;
        start_req = 1'b0;
        @(negedge clk);
        chk("ignored_busy", busy, 1);
        chk("ignored_nack", nack, 0);
        dur_x = 0;
        while (done !== 1'b1 && dur_x < 6000) begin
            @(negedge clk);
            dur_x++;
        end
        chk("ignored_done_seen", done, 1);
        start_req = 1'b1;
        @(posedge clk); #1;
        start_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("req_in_done_ignored", busy, 0);
        check_txn("ignored_req");

        for (int k = 0; k < 10; k++) begin
            bit         r;
            logic [6:0] d;
            logic [7:0] ra, w, rd;
            r  = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT_ADDR;
            ra = 8'($urandom);
            w  = 8'($urandom);
            rd = 8'($urandom);
            tgt_rd = rd;
            model_txn(r, d, ra, w, rd);
            start_txn(r, d, ra, w);
            finish_txn(dur_x);
            check_txn($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
